// File: rtl/tictactoe_pkg.sv
// ---------------------------------------------------------------------------
// tictactoe_pkg
// Types and constants shared by the tic-tac-toe blocks: the cell encoding,
// the board checker state type, the board size and the table of the eight
// winning lines. gameController imports the same package.
// ---------------------------------------------------------------------------
package tictactoe_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Encoding 2'b01 is deliberately unused, so it is never a legal move.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b10,
    O     = 2'b11
  } cellStateType;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } checkerStateType;

  // Cell indices of each winning line. The checker scans them in this order,
  // so a line's position here fixes how long its win takes to be reported.
  localparam logic [3:0] LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/tictactoe_line_eval.sv
// ---------------------------------------------------------------------------
// tictactoe_line_eval
// Combinational check of one winning line.
// Ports:
//   cell_a, cell_b, cell_c : the three cell values of the line
//   match                  : all three are equal and not EMPTY
//   value                  : the shared cell value when match is high, else EMPTY
// ---------------------------------------------------------------------------
module tictactoe_line_eval
  import tictactoe_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  output logic       match,
  output logic [1:0] value
);

  always_comb begin
    match = (cell_a == cell_b) && (cell_b == cell_c) && (cell_a != EMPTY);
    value = match ? cell_a : EMPTY;
  end

endmodule

// File: rtl/game_board_checker.sv
// ---------------------------------------------------------------------------
// game_board_checker
// Holds the 3x3 board, commits moves from gameController and then scans the
// eight winning lines one per clock to decide win, draw or continue.
// Ports:
//   ph2        : clock, everything updates on its rising edge
//   reset      : synchronous active-high reset, highest priority
//   cellWrite  : one-cycle request to write cellState into cell addr
//   addr       : target cell, 0..8 valid
//   cellState  : value to write, X=2'b10 or O=2'b11
//   newGame    : clear board and counters, return to IDLE
//   gameIsDone : high in DONE (win or draw)
//   winner     : winning symbol, EMPTY on draw or while not done
//   busy       : high while lines are being scanned
//   writeErr   : one-cycle pulse after a rejected write
//   moveCount  : number of accepted moves, 0..9
//   board      : packed board, cell i at bits [2i+1:2i]
// ---------------------------------------------------------------------------
module game_board_checker
  import tictactoe_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CELL_W = 2
) (
  input  logic                      ph2,
  input  logic                      reset,
  input  logic                      cellWrite,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [CELL_W-1:0]         cellState,
  input  logic                      newGame,
  output logic                      gameIsDone,
  output logic [CELL_W-1:0]         winner,
  output logic                      busy,
  output logic                      writeErr,
  output logic [3:0]                moveCount,
  output logic [CELL_W*NUM_CELLS-1:0] board
);

  checkerStateType   state;
  logic [2:0]        line_idx;
  logic [CELL_W-1:0] cells [NUM_CELLS];

  logic              line_match;
  logic [1:0]        line_value;
  logic              addr_ok;
  logic              write_ok;
  logic              accept;

  // A single evaluator is shared by all lines; line_idx picks the cells.
  tictactoe_line_eval u_line_eval (
    .cell_a (cells[LINES[line_idx][0]]),
    .cell_b (cells[LINES[line_idx][1]]),
    .cell_c (cells[LINES[line_idx][2]]),
    .match  (line_match),
    .value  (line_value)
  );

  // The address is range-checked before the occupancy lookup is trusted.
  always_comb begin
    addr_ok  = addr < ADDR_W'(NUM_CELLS);
    write_ok = addr_ok && (cells[addr] == EMPTY) &&
               ((cellState == X) || (cellState == O));
    accept   = cellWrite && (state == IDLE) && write_ok;
  end

  always_comb begin
    board = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      board[CELL_W*i +: CELL_W] = cells[i];
    end
  end

  // Board, scan FSM and all status outputs. newGame beats any write in the
  // same cycle and that write is dropped without raising writeErr.
  always_ff @(posedge ph2) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++) cells[i] <= EMPTY;
      state      <= IDLE;
      line_idx   <= 3'd0;
      moveCount  <= 4'd0;
      gameIsDone <= 1'b0;
      winner     <= EMPTY;
      busy       <= 1'b0;
      writeErr   <= 1'b0;
    end else if (newGame) begin
      for (int i = 0; i < NUM_CELLS; i++) cells[i] <= EMPTY;
      state      <= IDLE;
      line_idx   <= 3'd0;
      moveCount  <= 4'd0;
      gameIsDone <= 1'b0;
      winner     <= EMPTY;
      busy       <= 1'b0;
      writeErr   <= 1'b0;
    end else begin
      writeErr <= cellWrite && !accept;
      case (state)
        IDLE: begin
          if (accept) begin
            cells[addr] <= cellState;
            moveCount   <= moveCount + 4'd1;
            line_idx    <= 3'd0;
            busy        <= 1'b1;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (line_match) begin
            winner     <= line_value;
            gameIsDone <= 1'b1;
            busy       <= 1'b0;
            line_idx   <= 3'd0;
            state      <= DONE;
          end else if (line_idx == 3'd7) begin
            busy     <= 1'b0;
            line_idx <= 3'd0;
            if (moveCount == 4'(NUM_CELLS)) begin
              winner     <= EMPTY;
              gameIsDone <= 1'b1;
              state      <= DONE;
            end else begin
              state <= IDLE;
            end
          end else begin
            line_idx <= line_idx + 3'd1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_board_checker.sv
// ---------------------------------------------------------------------------
// tb_game_board_checker
// Directed bench for game_board_checker: win on the first line, win on the
// last line, full-board draw, rejected writes, newGame in DONE and reset in
// the middle of a scan. Expected values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_game_board_checker;

  logic        ph2;
  logic        reset;
  logic        cellWrite;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic        newGame;
  logic        gameIsDone;
  logic [1:0]  winner;
  logic        busy;
  logic        writeErr;
  logic [3:0]  moveCount;
  logic [17:0] board;

  int checkCount = 0;
  int errorCount = 0;

  game_board_checker #(.ADDR_W(4), .CELL_W(2)) dut (
    .ph2        (ph2),
    .reset      (reset),
    .cellWrite  (cellWrite),
    .addr       (addr),
    .cellState  (cellState),
    .newGame    (newGame),
    .gameIsDone (gameIsDone),
    .winner     (winner),
    .busy       (busy),
    .writeErr   (writeErr),
    .moveCount  (moveCount),
    .board      (board)
  );

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge ph2);
    #1;
  endtask

  // One-cycle write request; returns 1 unit after the edge that samples it.
  task automatic applyStimulus(input logic [3:0] a, input logic [1:0] s);
    @(negedge ph2);
    cellWrite = 1'b1;
    addr      = a;
    cellState = s;
    @(posedge ph2);
    #1;
    cellWrite = 1'b0;
  endtask

  task automatic pulseNewGame();
    @(negedge ph2);
    newGame = 1'b1;
    @(posedge ph2);
    #1;
    newGame = 1'b0;
  endtask

  // Wait for the scan to finish, bounded so a stuck busy still ends the run.
  task automatic waitNotBusy(input string tag);
    int cycles = 0;
    while (busy && cycles < 20) begin
      waitEdges(1);
      cycles++;
    end
    if (busy) checkOutput({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  // Rejected write: pulse on the next cycle only, state left untouched.
  task automatic rejectCheck(input string tag, input logic [3:0] a,
                             input logic [1:0] s, input logic [3:0] expMoves,
                             input logic [17:0] expBoard);
    applyStimulus(a, s);
    checkOutput({tag, "_err"},   32'(writeErr),  32'd1);
    checkOutput({tag, "_moves"}, 32'(moveCount), 32'(expMoves));
    checkOutput({tag, "_board"}, 32'(board),     32'(expBoard));
    waitEdges(1);
    checkOutput({tag, "_errlow"}, 32'(writeErr), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    cellWrite = 1'b0;
    addr      = 4'd0;
    cellState = 2'b00;
    newGame   = 1'b0;
    waitEdges(2);
    @(negedge ph2);
    reset = 1'b0;
    #1;

    $display("[TB] reset state");
    checkOutput("rst_done",   32'(gameIsDone), 32'd0);
    checkOutput("rst_winner", 32'(winner),     32'd0);
    checkOutput("rst_busy",   32'(busy),       32'd0);
    checkOutput("rst_err",    32'(writeErr),   32'd0);
    checkOutput("rst_moves",  32'(moveCount),  32'd0);
    checkOutput("rst_board",  32'(board),      32'd0);

    // Game 1: X wins on line 0, reported one edge after the last move.
    $display("[TB] game 1: X wins line 0");
    applyStimulus(4'd0, 2'b10);
    checkOutput("g1_busy_n0", 32'(busy), 32'd1);
    waitEdges(7);
    checkOutput("g1_busy_n7", 32'(busy), 32'd1);
    waitEdges(1);
    checkOutput("g1_busy_n8", 32'(busy), 32'd0);
    checkOutput("g1_done_n8", 32'(gameIsDone), 32'd0);
    applyStimulus(4'd3, 2'b11); waitNotBusy("g1_m2");
    applyStimulus(4'd1, 2'b10); waitNotBusy("g1_m3");
    applyStimulus(4'd4, 2'b11); waitNotBusy("g1_m4");
    applyStimulus(4'd2, 2'b10);
    checkOutput("g1_done_n0", 32'(gameIsDone), 32'd0);
    waitEdges(1);
    checkOutput("g1_done",   32'(gameIsDone), 32'd1);
    checkOutput("g1_winner", 32'(winner),     32'd2);
    checkOutput("g1_busy",   32'(busy),       32'd0);
    checkOutput("g1_moves",  32'(moveCount),  32'd5);
    checkOutput("g1_board",  32'(board),      32'h003EA);
    rejectCheck("rej_done", 4'd5, 2'b10, 4'd5, 18'h003EA);

    // newGame together with a write in DONE: cleared, write dropped silently.
    $display("[TB] newGame with cellWrite in DONE");
    @(negedge ph2);
    newGame   = 1'b1;
    cellWrite = 1'b1;
    addr      = 4'd5;
    cellState = 2'b10;
    @(posedge ph2);
    #1;
    newGame   = 1'b0;
    cellWrite = 1'b0;
    checkOutput("ng_board",  32'(board),      32'd0);
    checkOutput("ng_moves",  32'(moveCount),  32'd0);
    checkOutput("ng_done",   32'(gameIsDone), 32'd0);
    checkOutput("ng_winner", 32'(winner),     32'd0);
    checkOutput("ng_err",    32'(writeErr),   32'd0);
    applyStimulus(4'd5, 2'b10);
    checkOutput("ng_acc_moves", 32'(moveCount), 32'd1);
    checkOutput("ng_acc_busy",  32'(busy),      32'd1);
    checkOutput("ng_acc_err",   32'(writeErr),  32'd0);
    checkOutput("ng_acc_board", 32'(board),     32'h00800);
    waitNotBusy("ng_acc");

    // Game 2: O wins on line 7 (cells 2,4,6), plus rejected writes.
    $display("[TB] game 2: O wins line 7, rejected writes");
    pulseNewGame();
    applyStimulus(4'd2, 2'b11); waitNotBusy("g2_m1");
    applyStimulus(4'd0, 2'b10);
    rejectCheck("rej_busy", 4'd7, 2'b10, 4'd2, 18'h00032);
    waitEdges(6);
    checkOutput("g2_m2_busy", 32'(busy), 32'd0);
    rejectCheck("rej_occupied", 4'd0, 2'b11, 4'd2, 18'h00032);
    rejectCheck("rej_addr9",    4'd9, 2'b10, 4'd2, 18'h00032);
    rejectCheck("rej_state00",  4'd8, 2'b00, 4'd2, 18'h00032);
    rejectCheck("rej_state01",  4'd8, 2'b01, 4'd2, 18'h00032);
    applyStimulus(4'd4, 2'b11); waitNotBusy("g2_m3");
    applyStimulus(4'd1, 2'b10); waitNotBusy("g2_m4");
    applyStimulus(4'd6, 2'b11);
    waitEdges(7);
    checkOutput("g2_busy_n7", 32'(busy),       32'd1);
    checkOutput("g2_done_n7", 32'(gameIsDone), 32'd0);
    waitEdges(1);
    checkOutput("g2_done",   32'(gameIsDone), 32'd1);
    checkOutput("g2_winner", 32'(winner),     32'd3);
    checkOutput("g2_busy",   32'(busy),       32'd0);
    checkOutput("g2_moves",  32'(moveCount),  32'd5);

    // Game 3: full board with no line, draw after the ninth move's scan.
    $display("[TB] game 3: draw");
    pulseNewGame();
    applyStimulus(4'd0, 2'b10); waitNotBusy("g3_m1");
    applyStimulus(4'd1, 2'b11); waitNotBusy("g3_m2");
    applyStimulus(4'd2, 2'b10); waitNotBusy("g3_m3");
    applyStimulus(4'd3, 2'b10); waitNotBusy("g3_m4");
    applyStimulus(4'd4, 2'b11); waitNotBusy("g3_m5");
    applyStimulus(4'd5, 2'b11); waitNotBusy("g3_m6");
    applyStimulus(4'd6, 2'b11); waitNotBusy("g3_m7");
    applyStimulus(4'd7, 2'b10); waitNotBusy("g3_m8");
    checkOutput("g3_m8_done", 32'(gameIsDone), 32'd0);
    applyStimulus(4'd8, 2'b10);
    waitEdges(7);
    checkOutput("g3_done_n7", 32'(gameIsDone), 32'd0);
    waitEdges(1);
    checkOutput("g3_done",   32'(gameIsDone), 32'd1);
    checkOutput("g3_winner", 32'(winner),     32'd0);
    checkOutput("g3_moves",  32'(moveCount),  32'd9);
    checkOutput("g3_busy",   32'(busy),       32'd0);

    // Reset while the scan sits on line 3.
    $display("[TB] reset mid-scan");
    pulseNewGame();
    applyStimulus(4'd0, 2'b10);
    waitEdges(3);
    @(negedge ph2);
    reset = 1'b1;
    @(posedge ph2);
    #1;
    reset = 1'b0;
    checkOutput("mr_done",   32'(gameIsDone), 32'd0);
    checkOutput("mr_winner", 32'(winner),     32'd0);
    checkOutput("mr_busy",   32'(busy),       32'd0);
    checkOutput("mr_err",    32'(writeErr),   32'd0);
    checkOutput("mr_moves",  32'(moveCount),  32'd0);
    checkOutput("mr_board",  32'(board),      32'd0);
    applyStimulus(4'd0, 2'b10);
    checkOutput("mr_acc_moves", 32'(moveCount), 32'd1);
    checkOutput("mr_acc_busy",  32'(busy),      32'd1);
    checkOutput("mr_acc_board", 32'(board),     32'h00002);
    checkOutput("mr_acc_err",   32'(writeErr),  32'd0);
    waitNotBusy("mr_acc");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
